// File: rtl/dma_priority_arbiter.sv
// Request synchroniser, priority resolver and HRQ/HLDA tenure FSM for an 8237A-style DMA engine.
// One channel is granted per bus tenure, and it stays granted until timing control reports end of service.
module dma_priority_arbiter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic       HLDA,
  output logic       HRQ,
  output logic [3:0] DACK,
  input  logic [3:0] mask_i,
  input  logic [3:0] sw_req_i,
  input  logic       rot_pri_i,
  input  logic       dreq_sense_i,
  input  logic       dack_sense_i,
  input  logic       ctrl_dis_i,
  input  logic       svc_done_i,
  output logic [1:0] chan_o,
  output logic       svc_start_o,
  output logic       svc_act_o,
  output logic       abort_o,
  output logic [2:0] fsm_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_GRANT = 3'd2;
  localparam logic [2:0] ST_SVC   = 3'd3;
  localparam logic [2:0] ST_REL   = 3'd4;

  // Handshake: HRQ is raised toward the CPU; a grant is made only in the
  // cycle HLDA is seen high. svc_start_o marks the grant and svc_done_i
  // from timing control ends the service.

  logic [2:0] state;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] dreq_sync;
  logic [3:0] req_eff;
  logic [3:0] dack_act;
  logic [1:0] ptr;
  logic [1:0] base;
  logic [1:0] idx;
  logic [1:0] winner;
  logic       found;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= 4'h0;
    end else begin
      sync_q[0] <= DREQ;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign dreq_sync = sync_q[SYNC_STAGES-1];
  assign req_eff   = ((dreq_sync ^ {4{dreq_sense_i}}) & ~mask_i) | sw_req_i;

  // Search begins at the rotate pointer; in fixed mode it is pinned to ch0.
  always_comb begin
    base   = rot_pri_i ? ptr : 2'd0;
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && req_eff[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      HRQ         <= 1'b0;
      dack_act    <= 4'h0;
      chan_o      <= 2'd0;
      svc_start_o <= 1'b0;
      svc_act_o   <= 1'b0;
      abort_o     <= 1'b0;
      ptr         <= 2'd0;
    end else begin
      svc_start_o <= 1'b0;
      abort_o     <= 1'b0;
      if (!rot_pri_i) ptr <= 2'd0;
      case (state)
        ST_IDLE: begin
          HRQ <= 1'b0;
          if ((|req_eff) && !ctrl_dis_i) begin
            state <= ST_REQ;
            HRQ   <= 1'b1;
          end
        end
        ST_REQ: begin
          // HRQ is already visible to the CPU, so ctrl_dis_i no longer blocks the grant.
          if (HLDA) begin
            if (|req_eff) begin
              state       <= ST_GRANT;
              chan_o      <= winner;
              dack_act    <= 4'b0001 << winner;
              svc_start_o <= 1'b1;
              svc_act_o   <= 1'b1;
            end else begin
              state <= ST_REL;
              HRQ   <= 1'b0;
            end
          end
        end
        ST_GRANT: begin
          state <= ST_SVC;
        end
        ST_SVC: begin
          // Done wins over a simultaneous HLDA fall.
          if (svc_done_i) begin
            state     <= ST_REL;
            HRQ       <= 1'b0;
            dack_act  <= 4'h0;
            svc_act_o <= 1'b0;
            if (rot_pri_i) ptr <= chan_o + 2'd1;
          end else if (!HLDA) begin
            state     <= ST_IDLE;
            HRQ       <= 1'b0;
            dack_act  <= 4'h0;
            svc_act_o <= 1'b0;
            abort_o   <= 1'b1;
          end
        end
        ST_REL: begin
          HRQ <= 1'b0;
          if (!HLDA) state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          HRQ       <= 1'b0;
          dack_act  <= 4'h0;
          svc_act_o <= 1'b0;
        end
      endcase
    end
  end

  assign DACK      = dack_sense_i ? dack_act : ~dack_act;
  assign fsm_state = state;

endmodule
